// File: rtl/deparser_pkg.sv
// Shared constants for the deparser: action word layout, container map, FSM encoding.
// Geometry is fixed to a 128-byte header and a 1024-bit PHV.
package deparser_pkg;
    localparam int HDR_BYTES   = 128;
    localparam int HDR_BITS    = 1024;
    localparam int NUM_ACTIONS = 10;
    localparam int ACT_W       = 16;

    localparam int ACT_VALID_BIT = 0;
    localparam int ACT_IDX_LSB   = 1;
    localparam int ACT_IDX_W     = 3;
    localparam int ACT_TYPE_LSB  = 4;
    localparam int ACT_TYPE_W    = 2;
    localparam int ACT_OFF_LSB   = 6;
    localparam int ACT_OFF_W     = 7;
    localparam int ACT_RSVD_LSB  = 13;

    localparam logic [1:0] DEP_TYPE_NONE = 2'b00;
    localparam logic [1:0] DEP_TYPE_2B   = 2'b01;
    localparam logic [1:0] DEP_TYPE_4B   = 2'b10;
    localparam logic [1:0] DEP_TYPE_6B   = 2'b11;

    localparam int CONT6_BASE = 640;
    localparam int CONT4_BASE = 384;
    localparam int CONT2_BASE = 256;
    localparam int CONT_W     = HDR_BITS - CONT2_BASE;
    localparam int VLAN_LSB   = 129;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RAM = 2'd1;
    localparam logic [1:0] ST_APPLY    = 2'd2;
    localparam logic [1:0] ST_OUTPUT   = 2'd3;

    function automatic logic [3:0] dep_type_bytes(input logic [1:0] t);
        case (t)
            DEP_TYPE_2B: return 4'd2;
            DEP_TYPE_4B: return 4'd4;
            DEP_TYPE_6B: return 4'd6;
            default:     return 4'd0;
        endcase
    endfunction
endpackage

// File: rtl/deparser_do_deparsing_sub_deparser.sv
// One deparse action: selects its container, byte-swaps it and aligns it to the offset.
// Latency: purely combinational.
// Backpressure: none; an action that is invalid or overruns the header yields an empty mask.
module sub_deparser
    import deparser_pkg::*;
(
    input  logic [ACT_W-1:0]     action,
    input  logic [CONT_W-1:0]    containers,
    output logic [HDR_BYTES-1:0] byte_en,
    output logic [HDR_BITS-1:0]  data
);
    logic [ACT_IDX_W-1:0]  idx;
    logic [ACT_TYPE_W-1:0] typ;
    logic [ACT_OFF_W-1:0]  off;
    logic [3:0]            nbytes;
    logic [47:0]           cont;
    logic [47:0]           swapped;
    logic [5:0]            nmask;
    logic                  hit;
    logic                  unused_rsvd;

    assign unused_rsvd = ^action[ACT_W-1:ACT_RSVD_LSB];

    always_comb begin
        idx    = action[ACT_IDX_LSB +: ACT_IDX_W];
        typ    = action[ACT_TYPE_LSB +: ACT_TYPE_W];
        off    = action[ACT_OFF_LSB +: ACT_OFF_W];
        nbytes = dep_type_bytes(typ);
        cont   = '0;
        case (typ)
            DEP_TYPE_2B: cont[15:0] = containers[16*int'(idx) +: 16];
            DEP_TYPE_4B: cont[31:0] = containers[CONT4_BASE - CONT2_BASE + 32*int'(idx) +: 32];
            DEP_TYPE_6B: cont       = containers[CONT6_BASE - CONT2_BASE + 48*int'(idx) +: 48];
            default:     cont       = '0;
        endcase

        // Container MSB byte lands at the lowest header byte of the field.
        swapped = '0;
        nmask   = '0;
        for (int b = 0; b < 6; b++) begin
            if (b < int'(nbytes)) begin
                swapped[8*b +: 8] = cont[8*(int'(nbytes) - 1 - b) +: 8];
                nmask[b]          = 1'b1;
            end
        end

        hit = action[ACT_VALID_BIT] && (typ != DEP_TYPE_NONE) &&
              (({1'b0, off} + {4'b0, nbytes}) <= 8'd128);

        byte_en = hit ? (HDR_BYTES'(nmask) << off) : '0;
        data    = hit ? (HDR_BITS'(swapped) << {off, 3'b000}) : '0;
    end
endmodule

// File: rtl/deparser_do_deparsing.sv
// Writes processed PHV containers back into the cached header segments per VLAN action list.
// Latency: accept in T, RAM address from T+1, output valid from T+3; one packet in flight.
// Backpressure: output held stable until depar_ready; no FIFO pop outside IDLE.
module deparser_do_deparsing
    import deparser_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 2,
    parameter int PKT_HDR_LEN        = 1024,
    parameter int C_PARSER_RAM_WIDTH = 160,
    parameter int C_VLANID_WIDTH     = 12
) (
    input  logic                                     axis_clk,
    input  logic                                     aresetn,
    input  logic [PKT_HDR_LEN-1:0]                   phv_in,
    input  logic                                     phv_valid_in,
    output logic                                     phv_rd,
    input  logic [C_AXIS_DATA_WIDTH*C_NUM_SEGS-1:0]  tdata_segs_in,
    input  logic                                     segs_valid_in,
    output logic                                     segs_rd,
    output logic [C_VLANID_WIDTH-1:0]                bram_addr,
    input  logic [C_PARSER_RAM_WIDTH-1:0]            bram_in,
    output logic [C_AXIS_DATA_WIDTH*C_NUM_SEGS-1:0]  depar_segs,
    output logic [C_AXIS_TUSER_WIDTH-1:0]            depar_tuser,
    output logic                                     depar_valid,
    input  logic                                     depar_ready
);
    localparam int SEG_W = C_AXIS_DATA_WIDTH * C_NUM_SEGS;

    logic [1:0]                    state;
    logic                          accept;
    logic [SEG_W-1:0]              seg_buf;
    logic [SEG_W-1:0]              seg_next;
    logic [CONT_W-1:0]             cont_buf;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_buf;
    logic [HDR_BYTES-1:0]          act_en   [NUM_ACTIONS];
    logic [HDR_BITS-1:0]           act_data [NUM_ACTIONS];
    logic                          unused_phv;

    assign unused_phv = ^{phv_in[CONT2_BASE-1:VLAN_LSB+C_VLANID_WIDTH],
                          phv_in[VLAN_LSB-1:C_AXIS_TUSER_WIDTH]};

    // Gated by aresetn so a FIFO is never popped while reset is held.
    assign accept  = aresetn && (state == ST_IDLE) && phv_valid_in && segs_valid_in;
    assign phv_rd  = accept;
    assign segs_rd = accept;

    // Action i sits at the top of the RAM word and descends.
    for (genvar g = 0; g < NUM_ACTIONS; g++) begin : g_act
        sub_deparser u_sub (
            .action     (bram_in[ACT_W*(NUM_ACTIONS-1-g) +: ACT_W]),
            .containers (cont_buf),
            .byte_en    (act_en[g]),
            .data       (act_data[g])
        );
    end

    // Later actions override earlier ones byte by byte.
    always_comb begin
        seg_next = seg_buf;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            for (int j = 0; j < HDR_BYTES; j++) begin
                if (act_en[i][j]) begin
                    seg_next[8*j +: 8] = act_data[i][8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            depar_valid <= 1'b0;
            depar_segs  <= '0;
            depar_tuser <= '0;
            bram_addr   <= '0;
            seg_buf     <= '0;
            cont_buf    <= '0;
            tuser_buf   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        seg_buf   <= tdata_segs_in;
                        cont_buf  <= phv_in[PKT_HDR_LEN-1 -: CONT_W];
                        tuser_buf <= phv_in[C_AXIS_TUSER_WIDTH-1:0];
                        bram_addr <= phv_in[VLAN_LSB +: C_VLANID_WIDTH];
                        state     <= ST_WAIT_RAM;
                    end
                end
                ST_WAIT_RAM: state <= ST_APPLY;
                ST_APPLY: begin
                    depar_segs  <= seg_next;
                    depar_tuser <= tuser_buf;
                    depar_valid <= 1'b1;
                    state       <= ST_OUTPUT;
                end
                default: begin
                    if (depar_ready) begin
                        depar_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
